sync_memory: RTL and testbench

SYNC_MEMORY -- requirements
Module: sync_memory

---
 rtl/sync_memory.sv | 169 ++++++++++++++++
 tb/tb_sync_memory.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_memory.sv
// -----------------------------------------------------------------------------
// sync_memory
//   Single-port synchronous word memory with a valid/ready request channel and
//   a fixed-latency, fully pipelined read response channel. After reset the
//   block can optionally sweep every word to zero before it accepts requests.
//
// Parameters
//   DATA_W        data word width in bits (1..64)
//   ADDR_W        address width in bits (1..12)
//   DEPTH         number of implemented words (1..2**ADDR_W)
//   RD_LAT        read latency in cycles (1..4)
//   CLEAR_ON_RST  1 = zero all words after reset, 0 = keep contents
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   req_valid  request present this cycle
//   req_ready  block accepts a request this cycle
//   req_write  1 = write, 0 = read (qualified by req_valid)
//   req_addr   word address
//   req_wdata  write data
//   rsp_valid  one-cycle pulse per accepted read, no backpressure
//   rsp_rdata  read data, forced to zero while rsp_valid is low
//   rsp_err    read addressed a word >= DEPTH (qualified by rsp_valid)
//   init_done  clearing finished, block operational
// -----------------------------------------------------------------------------
module sync_memory #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 5,
   parameter int DEPTH        = 32,
   parameter int RD_LAT       = 1,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   // Storage index width; at least one bit so a single-word memory still works.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Clear counter sized to hold DEPTH without wrapping.
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state;
   logic [CNT_W-1:0]  init_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              rd_hit;
   logic              wr_hit;
   logic              addr_ok;
   logic [IDX_W-1:0]  req_idx;
   logic [IDX_W-1:0]  init_idx;
   logic [DATA_W-1:0] rd_data;

   logic              pipe_valid [RD_LAT];
   logic              pipe_err   [RD_LAT];
   logic [DATA_W-1:0] pipe_data  [RD_LAT];

   // -------------------------------------------------------------------------
   // Request decode
   // -------------------------------------------------------------------------
   // req_ready is masked by rst so nothing can be accepted while reset is held,
   // including the cycle before the first reset edge is seen.
   always_comb begin
      req_ready = (state == ST_RUN) && !rst;
      init_done = (state == ST_RUN) && !rst;
      accept    = req_valid && req_ready;
      rd_hit    = accept && !req_write;
      wr_hit    = accept &&  req_write;
      addr_ok   = (int'(req_addr) < DEPTH);
      req_idx   = req_addr[IDX_W-1:0];
      init_idx  = init_cnt[IDX_W-1:0];
   end

   // -------------------------------------------------------------------------
   // Control FSM: INIT sweeps words 0..DEPTH-1, then RUN forever until reset.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               if (CLEAR_ON_RST == 0) begin
                  state <= ST_RUN;
               end else if (init_cnt == LAST_WORD) begin
                  state <= ST_RUN;
               end else begin
                  init_cnt <= init_cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               state <= ST_RUN;
            end
            default: begin
               state    <= ST_INIT;
               init_cnt <= '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Storage. The clear sweep and request writes are mutually exclusive since
   // requests are only accepted in RUN. Out-of-range writes are dropped.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         if ((state == ST_INIT) && (CLEAR_ON_RST != 0)) begin
            mem[init_idx] <= '0;
         end else if (wr_hit && addr_ok) begin
            mem[req_idx] <= req_wdata;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read pipeline. Stage 0 captures the array at acceptance, so a write on the
   // previous cycle is already visible. Data is zeroed for idle slots, writes
   // and out-of-range reads, which keeps rsp_rdata at 0 whenever rsp_valid=0.
   // -------------------------------------------------------------------------
   always_comb begin
      rd_data = '0;
      if (rd_hit && addr_ok) begin
         rd_data = mem[req_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_err[i]   <= 1'b0;
            pipe_data[i]  <= '0;
         end
      end else begin
         pipe_valid[0] <= rd_hit;
         pipe_err[0]   <= rd_hit && !addr_ok;
         pipe_data[0]  <= rd_data;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   always_comb begin
      rsp_valid = pipe_valid[RD_LAT-1];
      rsp_err   = pipe_err[RD_LAT-1];
      rsp_rdata = pipe_data[RD_LAT-1];
   end

endmodule

// File: tb/tb_sync_memory.sv
// -----------------------------------------------------------------------------
// tb_sync_memory
//   Directed bench for sync_memory. Five instances cover the parameter sets of
//   interest, all on one clock, each with its own reset and request inputs:
//     0: defaults
//     1: DEPTH=20, RD_LAT=3
//     2: RD_LAT=2
//     3: RD_LAT=4
//     4: CLEAR_ON_RST=0
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_sync_memory;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [4:0]       rst;
   logic [4:0]       req_valid;
   logic [4:0]       req_write;
   logic [4:0][4:0]  req_addr;
   logic [4:0][7:0]  req_wdata;
   logic [4:0]       req_ready;
   logic [4:0]       rsp_valid;
   logic [4:0][7:0]  rsp_rdata;
   logic [4:0]       rsp_err;
   logic [4:0]       init_done;

   int checks   = 0;
   int failures = 0;

   sync_memory u_dut0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
      .init_done(init_done[0])
   );

   sync_memory #(.DEPTH(20), .RD_LAT(3)) u_dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
      .init_done(init_done[1])
   );

   sync_memory #(.RD_LAT(2)) u_dut2 (
      .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
      .init_done(init_done[2])
   );

   sync_memory #(.RD_LAT(4)) u_dut3 (
      .clk(clk), .rst(rst[3]), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
      .req_write(req_write[3]), .req_addr(req_addr[3]), .req_wdata(req_wdata[3]),
      .rsp_valid(rsp_valid[3]), .rsp_rdata(rsp_rdata[3]), .rsp_err(rsp_err[3]),
      .init_done(init_done[3])
   );

   sync_memory #(.CLEAR_ON_RST(0)) u_dut4 (
      .clk(clk), .rst(rst[4]), .req_valid(req_valid[4]), .req_ready(req_ready[4]),
      .req_write(req_write[4]), .req_addr(req_addr[4]), .req_wdata(req_wdata[4]),
      .rsp_valid(rsp_valid[4]), .rsp_rdata(rsp_rdata[4]), .rsp_err(rsp_err[4]),
      .init_done(init_done[4])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for two edges and check every output is in its reset state.
   task automatic reset_assert(input int k);
      rst[k]       = 1'b1;
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      step();
      step();
      check($sformatf("rst%0d_ready", k),     64'(req_ready[k]), 64'd0);
      check($sformatf("rst%0d_init_done", k), 64'(init_done[k]), 64'd0);
      check($sformatf("rst%0d_rsp_valid", k), 64'(rsp_valid[k]), 64'd0);
      check($sformatf("rst%0d_rsp_rdata", k), 64'(rsp_rdata[k]), 64'd0);
      check($sformatf("rst%0d_rsp_err", k),   64'(rsp_err[k]),   64'd0);
   endtask

   // Called right after rst is released: counts edges until req_ready rises.
   task automatic wait_ready(input int k, input int exp_n);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!req_ready[k] && n < 200);
      check($sformatf("init%0d_cycles", k), 64'(n), 64'(exp_n));
      check($sformatf("init%0d_done", k), 64'(init_done[k]), 64'd1);
   endtask

   task automatic wr(input int k, input int a, input logic [7:0] d);
      req_valid[k] = 1'b1;
      req_write[k] = 1'b1;
      req_addr[k]  = 5'(a);
      req_wdata[k] = d;
      step();
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      check($sformatf("wr%0d_a%0d_no_rsp", k, a), 64'(rsp_valid[k]), 64'd0);
      check($sformatf("wr%0d_a%0d_rdata0", k, a), 64'(rsp_rdata[k]), 64'd0);
   endtask

   // Single read; the response must appear exactly lat edges after acceptance
   // counting the accepting edge, and last exactly one cycle.
   task automatic rd(input int k, input int a, input logic [7:0] ed, input logic ee, input int lat);
      req_valid[k] = 1'b1;
      req_write[k] = 1'b0;
      req_addr[k]  = 5'(a);
      step();
      req_valid[k] = 1'b0;
      for (int c = 1; c < lat; c++) begin
         check($sformatf("rd%0d_a%0d_early", k, a), 64'(rsp_valid[k]), 64'd0);
         step();
      end
      check($sformatf("rd%0d_a%0d_valid", k, a), 64'(rsp_valid[k]), 64'd1);
      check($sformatf("rd%0d_a%0d_rdata", k, a), 64'(rsp_rdata[k]), 64'(ed));
      check($sformatf("rd%0d_a%0d_err", k, a),   64'(rsp_err[k]),   64'(ee));
      step();
      check($sformatf("rd%0d_a%0d_pulse", k, a), 64'(rsp_valid[k]), 64'd0);
      check($sformatf("rd%0d_a%0d_idle0", k, a), 64'(rsp_rdata[k]), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = '1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;

      // ---- instance 0: defaults ----
      reset_assert(0);
      // A write held during clearing must not be accepted.
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 5'd3;
      req_wdata[0] = 8'hEE;
      rst[0]       = 1'b0;
      wait_ready(0, 32);
      req_valid[0] = 1'b0;
      req_write[0] = 1'b0;
      // Pipelined sweep of all words, one response per edge.
      for (int a = 0; a < 32; a++) begin
         req_valid[0] = 1'b1;
         req_addr[0]  = 5'(a);
         step();
         check($sformatf("A_sweep_valid_%0d", a), 64'(rsp_valid[0]), 64'd1);
         check($sformatf("A_sweep_rdata_%0d", a), 64'(rsp_rdata[0]), 64'd0);
         check($sformatf("A_sweep_err_%0d", a),   64'(rsp_err[0]),   64'd0);
      end
      req_valid[0] = 1'b0;
      step();
      check("A_sweep_end", 64'(rsp_valid[0]), 64'd0);
      wr(0, 5, 8'h5F);
      rd(0, 5, 8'h5F, 1'b0, 1);
      wr(0, 31, 8'hC3);
      rd(0, 31, 8'hC3, 1'b0, 1);
      // Reset again: written words must come back cleared.
      reset_assert(0);
      rst[0] = 1'b0;
      wait_ready(0, 32);
      rd(0, 5, 8'h00, 1'b0, 1);
      rd(0, 31, 8'h00, 1'b0, 1);

      // ---- instance 1: DEPTH=20, RD_LAT=3 ----
      reset_assert(1);
      rst[1] = 1'b0;
      wait_ready(1, 20);
      wr(1, 7, 8'hA5);
      rd(1, 7, 8'hA5, 1'b0, 3);
      wr(1, 25, 8'h3C);
      rd(1, 25, 8'h00, 1'b1, 3);
      rd(1, 5, 8'h00, 1'b0, 3);
      rd(1, 19, 8'h00, 1'b0, 3);
      wr(1, 19, 8'h99);
      rd(1, 19, 8'h99, 1'b0, 3);
      rd(1, 20, 8'h00, 1'b1, 3);

      // ---- instance 2: RD_LAT=2, back-to-back reads ----
      reset_assert(2);
      rst[2] = 1'b0;
      wait_ready(2, 32);
      wr(2, 1, 8'h11);
      wr(2, 2, 8'h22);
      wr(2, 3, 8'h33);
      req_valid[2] = 1'b1;
      req_write[2] = 1'b0;
      req_addr[2]  = 5'd1;
      step();
      check("C_gap", 64'(rsp_valid[2]), 64'd0);
      req_addr[2] = 5'd2;
      step();
      check("C_r1_valid", 64'(rsp_valid[2]), 64'd1);
      check("C_r1_rdata", 64'(rsp_rdata[2]), 64'h11);
      req_addr[2] = 5'd3;
      step();
      check("C_r2_valid", 64'(rsp_valid[2]), 64'd1);
      check("C_r2_rdata", 64'(rsp_rdata[2]), 64'h22);
      req_valid[2] = 1'b0;
      step();
      check("C_r3_valid", 64'(rsp_valid[2]), 64'd1);
      check("C_r3_rdata", 64'(rsp_rdata[2]), 64'h33);
      step();
      check("C_end", 64'(rsp_valid[2]), 64'd0);

      // ---- instance 3: RD_LAT=4, reset kills an in-flight read ----
      reset_assert(3);
      rst[3] = 1'b0;
      wait_ready(3, 32);
      wr(3, 9, 8'h77);
      req_valid[3] = 1'b1;
      req_write[3] = 1'b0;
      req_addr[3]  = 5'd9;
      step();
      req_valid[3] = 1'b0;
      check("D_inflight_0", 64'(rsp_valid[3]), 64'd0);
      step();
      check("D_inflight_1", 64'(rsp_valid[3]), 64'd0);
      rst[3] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         check($sformatf("D_flushed_%0d", c), 64'(rsp_valid[3]), 64'd0);
         check($sformatf("D_rst_ready_%0d", c), 64'(req_ready[3]), 64'd0);
      end
      rst[3] = 1'b0;
      wait_ready(3, 32);
      check("D_no_late_rsp", 64'(rsp_valid[3]), 64'd0);
      rd(3, 9, 8'h00, 1'b0, 4);

      // ---- instance 4: CLEAR_ON_RST=0 keeps contents ----
      reset_assert(4);
      rst[4] = 1'b0;
      wait_ready(4, 1);
      wr(4, 0, 8'h5A);
      rst[4] = 1'b1;
      step();
      check("E_rst_ready", 64'(req_ready[4]), 64'd0);
      rst[4] = 1'b0;
      step();
      check("E_ready_after", 64'(req_ready[4]), 64'd1);
      rd(4, 0, 8'h5A, 1'b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
